// File: rtl/chronos_runtime_config_if.sv
// Register bus between the host-side OCL register path and chronos_runtime_config.
//   master : host side; drives write/read requests and consumes wready/rvalid/rdata.
//   slave  : register block side; accepts writes, returns read data one cycle later.
// Signals:
//   reg_wvalid/reg_waddr/reg_wdata : write request, held by the host until reg_wready.
//   reg_wready                     : write accepted in the cycle wvalid && wready.
//   reg_arvalid/reg_araddr         : read request, always accepted.
//   reg_rvalid/reg_rdata           : read response, one cycle after the request.
interface chronos_runtime_config_if #(
   parameter int AW        = 4,
   parameter int CFG_WIDTH = 32
);
   logic                 reg_wvalid;
   logic [AW-1:0]        reg_waddr;
   logic [CFG_WIDTH-1:0] reg_wdata;
   logic                 reg_wready;
   logic                 reg_arvalid;
   logic [AW-1:0]        reg_araddr;
   logic                 reg_rvalid;
   logic [CFG_WIDTH-1:0] reg_rdata;

   modport master (
      output reg_wvalid, reg_waddr, reg_wdata, reg_arvalid, reg_araddr,
      input  reg_wready, reg_rvalid, reg_rdata
   );

   modport slave (
      input  reg_wvalid, reg_waddr, reg_wdata, reg_arvalid, reg_araddr,
      output reg_wready, reg_rvalid, reg_rdata
   );
endinterface

// File: rtl/chronos_runtime_config.sv
// Runtime configuration register block.
// Holds N_CFG_REGS shadow words written by the host; a commit quiesces the
// masked tiles, waits for them to drain (bounded by TIMEOUT_CYCLES, 0 = no
// bound) and then copies shadow to active in a single edge.
// Ports:
//   clk, rstn      : clock, synchronous active-low reset.
//   reg_bus        : register bus (slave modport), see chronos_runtime_config_if.
//   tile_idle      : per-tile drained indication.
//   quiesce_req    : asks the tiles to stop dequeuing (DRAIN and APPLY).
//   cfg_tile_mask  : tiles taking part in a commit.
//   cfg_active     : active words, word i at [i*CFG_WIDTH +: CFG_WIDTH].
//   cfg_update     : one-cycle pulse in the cycle new active values appear.
//   busy           : high whenever a commit is in progress.
// Address map: 0..N-1 shadow, N CTRL (bit0 = commit), N+1 TILE_MASK,
// N+2 STATUS {count[15:8], timeout_err[1], busy[0]}, N+3 VERSION.
module chronos_runtime_config #(
   parameter int N_TILES        = 8,
   parameter int N_CFG_REGS     = 8,
   parameter int CFG_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CFG_VERSION    = 10
) (
   input  logic                            clk,
   input  logic                            rstn,
   chronos_runtime_config_if.slave         reg_bus,
   input  logic [N_TILES-1:0]              tile_idle,
   output logic                            quiesce_req,
   output logic [N_TILES-1:0]              cfg_tile_mask,
   output logic [N_CFG_REGS*CFG_WIDTH-1:0] cfg_active,
   output logic                            cfg_update,
   output logic                            busy
);
   localparam int AW = $clog2(N_CFG_REGS + 4);
   localparam logic [AW-1:0] A_CTRL   = AW'(N_CFG_REGS);
   localparam logic [AW-1:0] A_MASK   = AW'(N_CFG_REGS + 1);
   localparam logic [AW-1:0] A_STATUS = AW'(N_CFG_REGS + 2);
   localparam logic [AW-1:0] A_VER    = AW'(N_CFG_REGS + 3);

   // The drain counter only has to reach TIMEOUT_CYCLES-1.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {IDLE, DRAIN, APPLY, DONE} state_t;

   state_t               state;
   logic [CFG_WIDTH-1:0] shadow [N_CFG_REGS];
   logic [CFG_WIDTH-1:0] active [N_CFG_REGS];
   logic [N_TILES-1:0]   tile_mask;
   logic                 timeout_err;
   logic [7:0]           commit_cnt;
   logic [CNT_W-1:0]     drain_cnt;
   logic [CFG_WIDTH-1:0] rd_mux;

   logic wr_status;
   logic wr_fire;
   logic commit_go;
   logic drained;
   logic timed_out;

   // STATUS writes must get through while busy so the host can always clear
   // the error; everything else stalls until the commit has finished.
   assign wr_status          = (reg_bus.reg_waddr == A_STATUS);
   assign reg_bus.reg_wready = (state == IDLE) || wr_status;
   assign wr_fire            = reg_bus.reg_wvalid && reg_bus.reg_wready;
   assign commit_go          = wr_fire && (reg_bus.reg_waddr == A_CTRL) && reg_bus.reg_wdata[0];

   // Unmasked tiles count as idle, so an empty mask drains immediately.
   assign drained   = &(tile_idle | ~tile_mask);
   assign timed_out = TIMEOUT_EN && (drain_cnt == CNT_LAST);

   // Commit sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         drain_cnt   <= '0;
         quiesce_req <= 1'b0;
         cfg_update  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (commit_go) begin
                  state       <= DRAIN;
                  drain_cnt   <= '0;
                  quiesce_req <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + CNT_W'(1);
               if (drained) begin
                  state <= APPLY;
               end else if (timed_out) begin
                  state       <= IDLE;
                  quiesce_req <= 1'b0;
                  busy        <= 1'b0;
               end
            end
            APPLY: begin
               state       <= DONE;
               quiesce_req <= 1'b0;
               cfg_update  <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               cfg_update <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               quiesce_req <= 1'b0;
               cfg_update  <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

   // Register file: shadow, mask, status and the shadow-to-active copy
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < N_CFG_REGS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         tile_mask   <= '1;
         timeout_err <= 1'b0;
         commit_cnt  <= '0;
      end else begin
         if (wr_fire) begin
            for (int i = 0; i < N_CFG_REGS; i++) begin
               if (reg_bus.reg_waddr == AW'(i)) shadow[i] <= reg_bus.reg_wdata;
            end
            if (reg_bus.reg_waddr == A_MASK) tile_mask <= reg_bus.reg_wdata[N_TILES-1:0];
         end
         // Setting the error wins over a host clear in the same cycle.
         if (state == DRAIN && !drained && timed_out) begin
            timeout_err <= 1'b1;
         end else if (wr_fire && wr_status) begin
            timeout_err <= 1'b0;
         end
         if (state == APPLY) begin
            for (int i = 0; i < N_CFG_REGS; i++) active[i] <= shadow[i];
            commit_cnt <= commit_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CFG_REGS; i++) begin
         if (reg_bus.reg_araddr == AW'(i)) rd_mux = shadow[i];
      end
      if (reg_bus.reg_araddr == A_MASK)   rd_mux = CFG_WIDTH'(tile_mask);
      if (reg_bus.reg_araddr == A_STATUS) rd_mux = CFG_WIDTH'({commit_cnt, 6'b0, timeout_err, busy});
      if (reg_bus.reg_araddr == A_VER)    rd_mux = CFG_WIDTH'(CFG_VERSION);
   end

   // Read response stage
   always_ff @(posedge clk) begin
      if (!rstn) begin
         reg_bus.reg_rvalid <= 1'b0;
         reg_bus.reg_rdata  <= '0;
      end else begin
         reg_bus.reg_rvalid <= reg_bus.reg_arvalid;
         reg_bus.reg_rdata  <= reg_bus.reg_arvalid ? rd_mux : '0;
      end
   end

   assign cfg_tile_mask = tile_mask;

   for (genvar g = 0; g < N_CFG_REGS; g++) begin : g_active
      assign cfg_active[g*CFG_WIDTH +: CFG_WIDTH] = active[g];
   end
endmodule
